// File: rtl/mux_scan_reg.sv
// Registered N-channel mux with manual select and round-robin scan modes,
// presenting captured words on a valid/ready output stage.
module mux_scan_reg #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned SEL_W = 2,
  parameter int unsigned DWELL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [SEL_W-1:0]  sel,
  input  logic              mode,
  input  logic              en,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sel_err
);

  // DWELL = 1 still needs a (constant-zero) one-bit counter.
  localparam int unsigned   DW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DwellMax = DW'(DWELL - 1);
  localparam logic [SEL_W-1:0] ChMax = SEL_W'(N_CH - 1);

  logic [W-1:0]     chan [N_CH];
  logic [W-1:0]     out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic             sel_err_q, sel_err_d;
  logic [SEL_W-1:0] ch_cnt_q, ch_cnt_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic             mode_q, mode_d;

  logic             slot_free, mode_chg, sel_ok, cap;
  logic [SEL_W-1:0] cap_ch;
  logic [W-1:0]     cap_data;

  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign chan[k] = in_data[k*W +: W];
  end

  // Next-state: mode tracking, scan counters, capture decision and output stage.
  always_comb begin
    slot_free   = !out_valid_q || out_ready;
    mode_chg    = (mode != mode_q);
    // Extra bit so sel >= N_CH is detectable when N_CH == 2**SEL_W.
    sel_ok      = ({1'b0, sel} < (SEL_W + 1)'(N_CH));
    mode_d      = mode;
    ch_cnt_d    = ch_cnt_q;
    dwell_d     = dwell_q;
    cap         = 1'b0;
    cap_ch      = sel;
    sel_err_d   = 1'b0;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;

    if (mode_chg) begin
      ch_cnt_d = '0;
      dwell_d  = '0;
    end else if (!mode) begin
      if (en && slot_free) begin
        if (sel_ok) begin
          cap = 1'b1;
        end else begin
          sel_err_d = 1'b1;
        end
      end
    end else if (en) begin
      if (dwell_q != DwellMax) begin
        dwell_d = dwell_q + 1'b1;
      end else if (slot_free) begin
        // Stalled expiry holds both counters, so no channel is skipped.
        cap      = 1'b1;
        cap_ch   = ch_cnt_q;
        dwell_d  = '0;
        ch_cnt_d = (ch_cnt_q == ChMax) ? '0 : ch_cnt_q + 1'b1;
      end
    end

    cap_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (cap_ch == SEL_W'(k)) cap_data = chan[k];
    end

    if (cap) begin
      out_data_d  = cap_data;
      out_ch_d    = cap_ch;
      out_valid_d = 1'b1;
    end
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      ch_cnt_q    <= '0;
      dwell_q     <= '0;
      mode_q      <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
      ch_cnt_q    <= ch_cnt_d;
      dwell_q     <= dwell_d;
      mode_q      <= mode_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
// Directed bench for mux_scan_reg: a 4-channel instance for the main function
// and a 3-channel instance for out-of-range select handling.
module tb_mux_scan_reg;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic [23:0] in_data3;
  logic [1:0]  sel;
  logic        mode;
  logic        en;
  logic        out_ready;

  logic [7:0]  out_data, out_data3;
  logic [1:0]  out_ch, out_ch3;
  logic        out_valid, out_valid3;
  logic        sel_err, sel_err3;

  int n_asserts;
  int n_fail;

  mux_scan_reg #(.N_CH(4), .W(8), .SEL_W(2), .DWELL(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .sel      (sel),
    .mode     (mode),
    .en       (en),
    .out_data (out_data),
    .out_ch   (out_ch),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sel_err  (sel_err)
  );

  mux_scan_reg #(.N_CH(3), .W(8), .SEL_W(2), .DWELL(4)) dut3 (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data3),
    .sel      (sel),
    .mode     (mode),
    .en       (en),
    .out_data (out_data3),
    .out_ch   (out_ch3),
    .out_valid(out_valid3),
    .out_ready(out_ready),
    .sel_err  (sel_err3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one active edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_data [4];
    n_asserts = 0;
    n_fail    = 0;
    exp_data[0] = 8'h11;
    exp_data[1] = 8'h22;
    exp_data[2] = 8'h33;
    exp_data[3] = 8'h44;

    rst       = 1'b1;
    in_data   = 32'h4433_2211;
    in_data3  = 24'h33_2211;
    sel       = 2'd0;
    mode      = 1'b0;
    en        = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    check("reset valid", {31'd0, out_valid}, 32'd0);
    check("reset data", {24'd0, out_data}, 32'd0);
    check("reset ch", {30'd0, out_ch}, 32'd0);
    check("reset sel_err", {31'd0, sel_err}, 32'd0);
    rst = 1'b0;

    // Manual sweep, one-cycle latency.
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      step();
      check("sweep valid", {31'd0, out_valid}, 32'd1);
      check("sweep data", {24'd0, out_data}, {24'd0, exp_data[k]});
      check("sweep ch", {30'd0, out_ch}, k);
    end

    // Backpressure: word 22 held while sel moves to 2.
    sel = 2'd1;
    step();
    check("bp first data", {24'd0, out_data}, 32'h22);
    out_ready = 1'b0;
    sel       = 2'd2;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp hold data", {24'd0, out_data}, 32'h22);
      check("bp hold ch", {30'd0, out_ch}, 32'd1);
      check("bp hold valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    step();
    check("bp release data", {24'd0, out_data}, 32'h33);
    check("bp release ch", {30'd0, out_ch}, 32'd2);
    en = 1'b0;
    step();
    check("en0 drains valid", {31'd0, out_valid}, 32'd0);
    check("en0 holds data", {24'd0, out_data}, 32'h33);

    // Scan wrap: mode-change edge, then a capture every 4th enabled edge.
    en   = 1'b1;
    mode = 1'b1;
    step();
    check("scan entry no cap", {31'd0, out_valid}, 32'd0);
    for (int r = 0; r < 5; r++) begin
      for (int d = 0; d < 3; d++) begin
        step();
        check("scan dwell no cap", {31'd0, out_valid}, 32'd0);
      end
      step();
      check("scan cap valid", {31'd0, out_valid}, 32'd1);
      check("scan cap ch", {30'd0, out_ch}, r % 4);
      check("scan cap data", {24'd0, out_data}, {24'd0, exp_data[r % 4]});
    end

    // Scan stall across dwell expiry: word ch0 held, then ch1 (not ch2).
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("stall valid", {31'd0, out_valid}, 32'd1);
      check("stall ch", {30'd0, out_ch}, 32'd0);
      check("stall data", {24'd0, out_data}, 32'h11);
    end
    out_ready = 1'b1;
    step();
    check("stall resume ch", {30'd0, out_ch}, 32'd1);
    check("stall resume data", {24'd0, out_data}, 32'h22);
    check("stall resume valid", {31'd0, out_valid}, 32'd1);

    // Mode toggle mid-dwell: no capture on the change edge, counters restart.
    step();
    step();
    mode = 1'b0;
    sel  = 2'd3;
    step();
    check("toggle no cap valid", {31'd0, out_valid}, 32'd0);
    check("toggle no cap ch", {30'd0, out_ch}, 32'd1);
    mode = 1'b1;
    step();
    check("toggle back no cap", {31'd0, out_valid}, 32'd0);
    for (int d = 0; d < 3; d++) begin
      step();
      check("toggle dwell no cap", {31'd0, out_valid}, 32'd0);
    end
    step();
    check("toggle restart ch", {30'd0, out_ch}, 32'd0);
    check("toggle restart data", {24'd0, out_data}, 32'h11);

    // Out-of-range select on the 3-channel instance.
    mode = 1'b0;
    step();
    sel = 2'd3;
    step();
    check("n3 sel_err pulse", {31'd0, sel_err3}, 32'd1);
    check("n3 no capture", {31'd0, out_valid3}, 32'd0);
    check("n4 sel3 no err", {31'd0, sel_err}, 32'd0);
    check("n4 sel3 data", {24'd0, out_data}, 32'h44);
    sel = 2'd0;
    step();
    check("n3 sel_err one cycle", {31'd0, sel_err3}, 32'd0);
    check("n3 sel0 data", {24'd0, out_data3}, 32'h11);
    sel = 2'd3;
    step();
    check("n3 sel_err again", {31'd0, sel_err3}, 32'd1);

    // Asynchronous reset mid-cycle with a pending word.
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async rst valid", {31'd0, out_valid}, 32'd0);
    check("async rst data", {24'd0, out_data}, 32'd0);
    check("async rst ch", {30'd0, out_ch}, 32'd0);
    check("async rst sel_err", {31'd0, sel_err3}, 32'd0);
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    sel       = 2'd2;
    step();
    check("post rst capture", {24'd0, out_data}, 32'h33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
